// File: rtl/tlul_req_fifo_pkg.sv
// Shared TL-UL widths (top_pkg) and the host request struct with its FIFO packing helpers (tlul_pkg).
package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = $clog2($clog2(TL_DBW) + 1);
    localparam int TL_APW = 2;
endpackage

package tlul_pkg;
    import top_pkg::*;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [TL_APW-1:0] a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    localparam int REQFIFO_WIDTH = $bits(tl_h2d_t) - 2;
    localparam int TL_MAX_SIZE   = $clog2(TL_DBW);

    typedef logic [REQFIFO_WIDTH-1:0] tl_req_packed_t;

    // Handshake bits (a_valid, d_ready) are regenerated at the output, so they are not stored.
    function automatic tl_req_packed_t pack_req(input tl_h2d_t req);
        return {req.a_opcode, req.a_param, req.a_size, req.a_source,
                req.a_address, req.a_mask, req.a_data};
    endfunction

    function automatic tl_h2d_t unpack_req(input tl_req_packed_t p, input logic a_valid,
                                           input logic d_ready);
        tl_h2d_t r;
        r = {a_valid, p, d_ready};
        return r;
    endfunction
endpackage

// File: rtl/tlul_req_fifo_mem.sv
// Depth x Width register array: one synchronous write port, one asynchronous read port.
module tlul_req_fifo_mem #(
    parameter int Depth = 4,
    parameter int Width = 83,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/tlul_req_fifo.sv
// TL-UL A-channel request FIFO with malformed-request screening.
// Optional per-entry even parity when TLUL_REQ_FIFO_PARITY_EN is defined.
module tlul_req_fifo
    import top_pkg::*;
    import tlul_pkg::*;
#(
    parameter int Depth = 4,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_h_i,
    output logic              a_ready_o,
    output tl_h2d_t           tl_d_o,
    input  logic              a_ready_i,
    output logic [CntW-1:0]   depth_o,
    output logic              err_valid_o,
    output logic [TL_AIW-1:0] err_source_o,
    output logic [TL_SZW-1:0] err_size_o
`ifdef TLUL_REQ_FIFO_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);
    localparam int PtrW = $clog2(Depth);
`ifdef TLUL_REQ_FIFO_PARITY_EN
    localparam int MemW = REQFIFO_WIDTH + 1;
`else
    localparam int MemW = REQFIFO_WIDTH;
`endif

    logic [PtrW-1:0] wptr, rptr;
    logic [CntW-1:0] count;
    logic            full, empty, accept, malformed, push, pop;
    tl_req_packed_t  wr_req, rd_req;
    logic [MemW-1:0] wdata, rdata;

    assign full      = (count == CntW'(Depth));
    assign empty     = (count == '0);
    assign a_ready_o = !full;
    assign depth_o   = count;

    assign malformed = (tl_h_i.a_size > TL_SZW'(TL_MAX_SIZE)) || (tl_h_i.a_mask == '0);
    assign accept    = tl_h_i.a_valid && !full;
    assign push      = accept && !malformed;
    assign pop       = !empty && a_ready_i;

    assign wr_req = pack_req(tl_h_i);
`ifdef TLUL_REQ_FIFO_PARITY_EN
    assign wdata  = {^wr_req, wr_req};
    assign rd_req = rdata[REQFIFO_WIDTH-1:0];
`else
    assign wdata  = wr_req;
    assign rd_req = rdata;
`endif

    assign tl_d_o = unpack_req(rd_req, !empty, tl_h_i.d_ready);

    tlul_req_fifo_mem #(
        .Depth (Depth),
        .Width (MemW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr),
        .wdata_i (wdata),
        .raddr_i (rptr),
        .rdata_o (rdata)
    );

    // Depth is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            err_valid_o  <= 1'b0;
            err_source_o <= '0;
            err_size_o   <= '0;
        end else begin
            if (push) wptr <= wptr + PtrW'(1);
            if (pop)  rptr <= rptr + PtrW'(1);
            if (push && !pop)      count <= count + CntW'(1);
            else if (pop && !push) count <= count - CntW'(1);
            err_valid_o <= accept && malformed;
            if (accept && malformed) begin
                err_source_o <= tl_h_i.a_source;
                err_size_o   <= tl_h_i.a_size;
            end
        end
    end

`ifdef TLUL_REQ_FIFO_PARITY_EN
    // Sticky: a corrupted entry is still delivered, only flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i)              parity_err_o <= 1'b0;
        else if (pop && ^rdata) parity_err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_tlul_req_fifo.sv
// Randomized and directed bench for tlul_req_fifo against a queue-based reference model.
module tb_tlul_req_fifo;
    import top_pkg::*;
    import tlul_pkg::*;

    localparam int Depth = 4;

    typedef struct {
        tl_h2d_t req;
        bit      bad_par;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    tl_h2d_t           tl_h, tl_d;
    logic              a_ready_o, dev_rdy;
    logic [2:0]        depth;
    logic              err_v;
    logic [TL_AIW-1:0] err_src;
    logic [TL_SZW-1:0] err_sz;
`ifdef TLUL_REQ_FIFO_PARITY_EN
    logic              par_err;
`endif

    int total = 0;
    int bad   = 0;

    entry_t            q[$];
    logic              m_err_v;
    logic [TL_AIW-1:0] m_err_src;
    logic [TL_SZW-1:0] m_err_sz;
    logic              m_par_err;

    tlul_req_fifo #(.Depth(Depth)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_h_i       (tl_h),
        .a_ready_o    (a_ready_o),
        .tl_d_o       (tl_d),
        .a_ready_i    (dev_rdy),
        .depth_o      (depth),
        .err_valid_o  (err_v),
        .err_source_o (err_src),
        .err_size_o   (err_sz)
`ifdef TLUL_REQ_FIFO_PARITY_EN
        ,
        .parity_err_o (par_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] payload(input tl_h2d_t r);
        return {45'd0, r.a_opcode, r.a_param, r.a_size, r.a_source, r.a_address, r.a_mask, r.a_data};
    endfunction

    function automatic tl_h2d_t mk_req(input logic v, input logic [TL_SZW-1:0] sz,
                                       input logic [TL_DBW-1:0] mk, input logic [TL_AIW-1:0] src);
        tl_h2d_t r;
        r.a_valid   = v;
        r.a_opcode  = 3'($urandom);
        r.a_param   = TL_APW'($urandom);
        r.a_size    = sz;
        r.a_source  = src;
        r.a_address = $urandom;
        r.a_mask    = mk;
        r.a_data    = $urandom;
        r.d_ready   = 1'($urandom);
        return r;
    endfunction

    function automatic tl_h2d_t idle_req();
        return mk_req(1'b0, 2'd2, 4'hF, 8'h00);
    endfunction

    // One clock: drive, check outputs against the model mid-cycle, then advance the model.
    task automatic cycle(input tl_h2d_t req, input logic rdy, output logic acc);
        int     n;
        logic   mal;
        entry_t e;
        tl_h    = req;
        dev_rdy = rdy;
        @(negedge clk);
        n = q.size();
        check("a_ready", a_ready_o, n != Depth);
        check("a_valid", tl_d.a_valid, n != 0);
        check("depth", depth, n);
        check("d_ready", tl_d.d_ready, req.d_ready);
        if (n != 0) check("head", payload(tl_d), payload(q[0].req));
        check("err_valid", err_v, m_err_v);
        check("err_source", err_src, m_err_src);
        check("err_size", err_sz, m_err_sz);
`ifdef TLUL_REQ_FIFO_PARITY_EN
        check("parity_err", par_err, m_par_err);
`endif
        @(posedge clk);
        acc = req.a_valid && (n != Depth);
        mal = ((1 << req.a_size) > TL_DBW) || (req.a_mask == 0);
        if (n != 0 && rdy) begin
            e = q.pop_front();
            if (e.bad_par) m_par_err = 1'b1;
        end
        if (acc && !mal) q.push_back('{req: req, bad_par: 1'b0});
        m_err_v = acc && mal;
        if (m_err_v) begin
            m_err_src = req.a_source;
            m_err_sz  = req.a_size;
        end
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tl_h    = mk_req(1'b1, 2'd2, 4'hF, 8'hEE);
        dev_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_err_v   = 1'b0;
        m_err_src = '0;
        m_err_sz  = '0;
        m_par_err = 1'b0;
    endtask

    initial begin
        logic acc;
        do_reset();

        // In-order delivery, one cycle after each push.
        for (int i = 1; i <= 3; i++) cycle(mk_req(1'b1, 2'd2, 4'hF, 8'(i)), 1'b1, acc);
        for (int i = 0; i < 2; i++) cycle(idle_req(), 1'b1, acc);

        // Fill to full with the consumer stalled; the fifth request is held upstream.
        for (int i = 1; i <= 4; i++) cycle(mk_req(1'b1, 2'd2, 4'hF, 8'(8'h10 + i)), 1'b0, acc);
        begin
            tl_h2d_t r5;
            r5 = mk_req(1'b1, 2'd2, 4'hF, 8'h15);
            for (int i = 0; i < 2; i++) cycle(r5, 1'b0, acc);
            acc = 1'b0;
            for (int i = 0; i < 8 && !acc; i++) cycle(r5, 1'b1, acc);
            if (!acc) check("fifth_accept_timeout", 1'b0, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(idle_req(), 1'b1, acc);

        // Malformed requests are handshaken, dropped and reported.
        cycle(mk_req(1'b1, 2'd3, 4'hF, 8'hA5), 1'b1, acc);
        cycle(idle_req(), 1'b1, acc);
        cycle(mk_req(1'b1, 2'd1, 4'h0, 8'h5A), 1'b1, acc);
        cycle(idle_req(), 1'b1, acc);
        cycle(idle_req(), 1'b1, acc);

        // Steady push+pop at level 2; pointers wrap several times.
        for (int i = 0; i < 2; i++) cycle(mk_req(1'b1, 2'd0, 4'h1, 8'(8'h20 + i)), 1'b0, acc);
        for (int i = 0; i < 20; i++) cycle(mk_req(1'b1, 2'd1, 4'h3, 8'(8'h30 + i)), 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(idle_req(), 1'b1, acc);

        // Reset with entries stored and a request on the bus.
        for (int i = 0; i < 3; i++) cycle(mk_req(1'b1, 2'd2, 4'hF, 8'(8'h40 + i)), 1'b0, acc);
        cycle(mk_req(1'b1, 2'd3, 4'hF, 8'h99), 1'b0, acc);
        do_reset();
        cycle(idle_req(), 1'b1, acc);

        // Randomized traffic; the second half drains faster.
        for (int i = 0; i < 600; i++) begin
            cycle(mk_req(1'($urandom_range(0, 9) < 7), TL_SZW'($urandom), TL_DBW'($urandom),
                         TL_AIW'($urandom)),
                  (i < 300) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 4) != 0), acc);
        end
        for (int i = 0; i < 6; i++) cycle(idle_req(), 1'b1, acc);

`ifdef TLUL_REQ_FIFO_PARITY_EN
        // Corrupt the parity bit of the stored head; data still arrives, error goes sticky.
        do_reset();
        cycle(mk_req(1'b1, 2'd2, 4'hF, 8'h77), 1'b0, acc);
        cycle(idle_req(), 1'b0, acc);
        u_dut.u_mem.mem[0][REQFIFO_WIDTH] = ~u_dut.u_mem.mem[0][REQFIFO_WIDTH];
        q[0].bad_par = 1'b1;
        for (int i = 0; i < 5; i++) cycle(mk_req(1'b1, 2'd2, 4'hF, 8'(8'h78 + i)), 1'b1, acc);
        do_reset();
        cycle(idle_req(), 1'b1, acc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
